uart_tx_fifo: RTL and testbench

8N1 UART transmitter with a small byte FIFO. It is the transmit counterpart to the panel's uart_rx and uses the same bit timing (CLKS_PER_BIT clocks per bit). Producers push bytes through a valid/ready handshake. The block serialises them LSB-first onto tx_serial. Typical uses are status or echo back to the host and loopback test of uart_rx.

---
 rtl/uart_tx_fifo.sv | 104 ++++++++++
 tb/tb_uart_tx_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed from a small circular byte FIFO.
// Ports:
//   clk        - system clock, all logic on posedge
//   reset      - synchronous active-high reset; aborts any frame and flushes the FIFO
//   tx_data    - byte to queue, sampled when tx_valid && tx_ready
//   tx_valid   - producer has a byte
//   tx_ready   - FIFO has room (registered count below FIFO_DEPTH)
//   tx_serial  - registered UART line, idle high, LSB first
//   tx_busy    - high while a frame (start..stop) is on the line
//   fifo_count - bytes queued, excluding the byte in flight
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 20,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_q, wr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [KW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            serial_q, serial_d;
    logic            busy_q, busy_d;
    logic            push, pop, bit_end;

    assign bit_end    = clk_cnt_q == KW'(CLKS_PER_BIT - 1);
    // Ready comes from the registered count, so a pop can never make room for a push while full.
    assign tx_ready   = count_q < CW'(FIFO_DEPTH);
    assign push       = tx_valid && tx_ready;
    // The FSM takes a byte from IDLE, or at the end of STOP so frames run back to back.
    assign pop        = (count_q != '0) && (state_q == IDLE || (state_q == STOP && bit_end));
    assign tx_serial  = serial_q;
    assign tx_busy    = busy_q;
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (count_q != '0) state_d = START;
            START: if (bit_end) state_d = DATA;
            DATA:  if (bit_end && bit_idx_q == 3'd7) state_d = STOP;
            STOP:  if (bit_end) state_d = (count_q != '0) ? START : IDLE;
        endcase
    end

    // Line level is computed from the next state so tx_serial falls on the same edge as the pop.
    always_comb begin
        serial_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[bit_idx_d] : 1'b1;
        busy_d   = state_d != IDLE;
    end

    always_comb begin
        count_d   = count_q + CW'(push) - CW'(pop);
        clk_cnt_d = (state_q == IDLE || bit_end) ? '0 : clk_cnt_q + KW'(1);
        bit_idx_d = (state_q != DATA) ? 3'd0 : bit_idx_q + 3'(bit_end);
        shift_d   = pop ? mem_q[rd_q] : shift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            rd_q      <= rd_q + PW'(pop);
            wr_q      <= wr_q + PW'(push);
            count_q   <= count_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_q] <= tx_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; accepted bytes are queued and a line monitor decodes every frame.
module tb_uart_tx_fifo;
    localparam int CPB   = 20;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_serial, tx_busy;
    logic [2:0] fifo_count;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_serial(tx_serial), .tx_busy(tx_busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         n_acc = 0;
    int         n_start = 0;
    bit         rst_seen = 1'b1;
    int         mon_k = -1;
    bit         in_frame = 1'b0;
    bit         exp_start = 1'b0;
    logic [7:0] cur = 8'h00;
    logic [7:0] rx = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model of the FIFO: every accepted byte joins the expected queue.
    always @(posedge clk) begin
        rst_seen = reset;
        if (reset) begin
            exp_q.delete();
            n_acc = 0;
        end else if (tx_valid && tx_ready) begin
            exp_q.push_back(tx_data);
            n_acc++;
        end
    end

    // Line monitor: frames are 10 bit-times, start low, data LSB first, stop high.
    always @(negedge clk) begin
        int   b;
        logic e;
        if (rst_seen) begin
            chk("reset_serial", 32'(tx_serial), 32'd1);
            chk("reset_busy", 32'(tx_busy), 32'd0);
            chk("reset_count", 32'(fifo_count), 32'd0);
            chk("reset_ready", 32'(tx_ready), 32'd1);
            in_frame  = 1'b0;
            n_start   = 0;
            mon_k     = -1;
            exp_start = 1'b0;
        end else begin
            if (!in_frame && tx_serial === 1'b0) begin
                chk("start_has_data", 32'(exp_q.size() > 0), 32'd1);
                cur      = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                in_frame = 1'b1;
                mon_k    = -1;
                rx       = 8'h00;
                n_start++;
            end
            if (exp_start) chk("no_idle_gap", 32'(in_frame && mon_k == -1), 32'd1);
            if (in_frame) begin
                mon_k++;
                b = mon_k / CPB;
                e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[3'(b - 1)];
                chk("serial_bit", 32'(tx_serial), 32'(e));
                chk("busy_in_frame", 32'(tx_busy), 32'd1);
                if (b >= 1 && b <= 8 && mon_k % CPB == CPB / 2) rx[3'(b - 1)] = tx_serial;
                if (mon_k == FRAME - 1) begin
                    chk("rx_byte", 32'(rx), 32'(cur));
                    in_frame = 1'b0;
                end
            end else begin
                chk("idle_serial", 32'(tx_serial), 32'd1);
                chk("idle_busy", 32'(tx_busy), 32'd0);
                mon_k = -1;
            end
            chk("fifo_count", 32'(fifo_count), 32'(n_acc - n_start));
            chk("tx_ready", 32'(tx_ready), 32'((n_acc - n_start) < DEPTH));
            exp_start = !in_frame && (n_acc - n_start) > 0;
        end
    end

    task automatic send(input logic [7:0] v);
        int t = 0;
        tx_data  = v;
        tx_valid = 1'b1;
        forever begin
            @(posedge clk);
            if (tx_ready) break;
            if (++t > 3000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %0h not accepted", v);
                break;
            end
        end
        #1 tx_valid = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (in_frame || n_acc != n_start || exp_q.size() != 0) begin
            @(posedge clk);
            if (++t > 20000) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: pending %0d", n_acc - n_start);
                break;
            end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_k(input int k);
        int t = 0;
        do begin
            @(posedge clk);
            if (++t > 3000) begin
                checks++;
                errors++;
                $display("FAIL frame_pos_timeout: k=%0d wanted %0d", mon_k, k);
                break;
            end
        end while (mon_k != k);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        send(8'h55);
        wait_idle();
        for (int i = 1; i <= 6; i++) send(8'(i));
        wait_idle();
        send(8'h11);
        for (int i = 8'h12; i <= 8'h15; i++) send(8'(i));
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        repeat (50) @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_idle();
        send(8'hA5);
        send(8'h01);
        send(8'h02);
        wait_k(4 * CPB + 5);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        send(8'h00);
        send(8'hFF);
        send(8'hA5);
        send(8'h3C);
        wait_idle();
        #1;
        send(8'h81);
        send(8'h82);
        wait_k(FRAME - 2);
        #1 tx_data = 8'h83;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_idle();
        repeat (25) begin
            repeat ($urandom_range(0, 250)) @(posedge clk);
            #1;
            send(8'($urandom));
        end
        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
